// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg: shared channel state encoding and index-width helper for the memory arbiter
package gpu_mem_pkg;
  localparam int STATE_BITS = 3;
  typedef enum logic [STATE_BITS-1:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } chan_state_t;
  function automatic int idx_bits(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_channel.sv
// mem_channel: one memory channel FSM; takes a claim (id/address/data), drives the memory side, relays ready back
module mem_channel
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int IDX_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 claim,
  input  logic                 claim_write,
  input  logic [IDX_BITS-1:0]  claim_id,
  input  logic [ADDR_BITS-1:0] claim_address,
  input  logic [DATA_BITS-1:0] claim_data,
  input  logic                 consumer_read_valid,
  input  logic                 consumer_write_valid,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  input  logic                 mem_write_ready,
  output logic                 idle,
  output logic [IDX_BITS-1:0]  id,
  output logic                 release_now,
  output logic                 read_relay,
  output logic                 write_relay,
  output logic [DATA_BITS-1:0] read_data,
  output logic                 mem_read_valid,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [DATA_BITS-1:0] mem_write_data
);
  chan_state_t state, next_state;
  always_ff @(posedge clk)
    state <= reset ? IDLE : next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:           if (claim) next_state = claim_write ? WRITE_WAITING : READ_WAITING;
      READ_WAITING:   if (mem_read_ready) next_state = READ_RELAYING;
      WRITE_WAITING:  if (mem_write_ready) next_state = WRITE_RELAYING;
      READ_RELAYING:  if (!consumer_read_valid) next_state = IDLE;
      WRITE_RELAYING: if (!consumer_write_valid) next_state = IDLE;
      default:        next_state = IDLE;
    endcase
  end
  always_comb begin
    idle            = state == IDLE;
    mem_read_valid  = state == READ_WAITING;
    mem_write_valid = state == WRITE_WAITING;
    read_relay      = state == READ_RELAYING;
    write_relay     = state == WRITE_RELAYING;
    release_now     = (read_relay && !consumer_read_valid) || (write_relay && !consumer_write_valid);
  end
  always_ff @(posedge clk)
    if (reset) begin
      id             <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      read_data      <= '0;
    end else begin
      if (idle && claim) begin
        id          <= claim_id;
        mem_address <= claim_address;
        if (claim_write) mem_write_data <= claim_data;
      end
      if (mem_read_valid && mem_read_ready) read_data <= mem_read_data;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority claim of NUM_CONSUMERS read/write ports onto NUM_CHANNELS memory channels
module mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);
  localparam int IDX_BITS = idx_bits(NUM_CONSUMERS);
  logic [NUM_CONSUMERS-1:0] write_valid, serving, serving_next, taken;
  logic [NUM_CHANNELS-1:0]  idle, claim, claim_write, release_now, read_relay, write_relay, chan_write_valid;
  logic [IDX_BITS-1:0]      claim_id [NUM_CHANNELS];
  logic [IDX_BITS-1:0]      id [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     claim_address [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     chan_address [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     claim_data [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     chan_read_data [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     chan_write_data [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     held_data [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     read_data [NUM_CONSUMERS];
  assign write_valid = WRITE_ENABLE != 0 ? consumer_write_valid : '0;
  // Channels claim in ascending order; taken accumulates so a later channel skips earlier picks.
  always_comb begin
    taken       = serving;
    claim       = '0;
    claim_write = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      claim_id[c]      = '0;
      claim_address[c] = '0;
      claim_data[c]    = '0;
      for (int i = 0; i < NUM_CONSUMERS; i++)
        if (idle[c] && !claim[c] && !taken[i] && (consumer_read_valid[i] || write_valid[i])) begin
          claim[c]         = 1'b1;
          claim_write[c]   = !consumer_read_valid[i];
          claim_id[c]      = IDX_BITS'(i);
          claim_address[c] = consumer_read_valid[i] ? consumer_read_address[i*ADDR_BITS +: ADDR_BITS]
                                                    : consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
          claim_data[c]    = consumer_write_data[i*DATA_BITS +: DATA_BITS];
          taken[i]         = 1'b1;
        end
    end
  end
  always_comb begin
    serving_next = taken;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (release_now[c]) serving_next[id[c]] = 1'b0;
  end
  always_ff @(posedge clk)
    serving <= reset ? '0 : serving_next;
  // Read data follows the relaying channel while ready is high, otherwise holds the last value shown.
  always_comb begin
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) read_data[i] = held_data[i];
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (read_relay[c]) begin
        consumer_read_ready[id[c]] = 1'b1;
        read_data[id[c]]           = chan_read_data[c];
      end
      if (write_relay[c]) consumer_write_ready[id[c]] = 1'b1;
    end
    for (int i = 0; i < NUM_CONSUMERS; i++) consumer_read_data[i*DATA_BITS +: DATA_BITS] = read_data[i];
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_CONSUMERS; i++) held_data[i] <= reset ? '0 : read_data[i];
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    mem_channel #(
      .ADDR_BITS(ADDR_BITS),
      .DATA_BITS(DATA_BITS),
      .IDX_BITS (IDX_BITS)
    ) u_chan (
      .clk                 (clk),
      .reset               (reset),
      .claim               (claim[g]),
      .claim_write         (claim_write[g]),
      .claim_id            (claim_id[g]),
      .claim_address       (claim_address[g]),
      .claim_data          (claim_data[g]),
      .consumer_read_valid (consumer_read_valid[id[g]]),
      .consumer_write_valid(write_valid[id[g]]),
      .mem_read_ready      (mem_read_ready[g]),
      .mem_read_data       (mem_read_data[g*DATA_BITS +: DATA_BITS]),
      .mem_write_ready     (mem_write_ready[g]),
      .idle                (idle[g]),
      .id                  (id[g]),
      .release_now         (release_now[g]),
      .read_relay          (read_relay[g]),
      .write_relay         (write_relay[g]),
      .read_data           (chan_read_data[g]),
      .mem_read_valid      (mem_read_valid[g]),
      .mem_write_valid     (chan_write_valid[g]),
      .mem_address         (chan_address[g]),
      .mem_write_data      (chan_write_data[g])
    );
    assign mem_read_address[g*ADDR_BITS +: ADDR_BITS]  = chan_address[g];
    assign mem_write_address[g*ADDR_BITS +: ADDR_BITS] = WRITE_ENABLE != 0 ? chan_address[g] : '0;
    assign mem_write_data[g*DATA_BITS +: DATA_BITS]    = WRITE_ENABLE != 0 ? chan_write_data[g] : '0;
    assign mem_write_valid[g]                          = WRITE_ENABLE != 0 && chan_write_valid[g];
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter (2 channels) against a behavioural memory/consumer model
module tb_mem_arbiter;
  logic clk = 1'b1;
  logic reset;
  logic [3:0] crv, crr, cwv, cwr;
  logic [31:0] cra, crd, cwa, cwd;
  logic [1:0] mrv, mrr, mwv, mwr;
  logic [15:0] mra, mrd, mwa, mwd;
  logic [7:0] rom [256];
  logic [8:0] wlog [256];
  int rcnt [2], wcnt [2], rdly [2], wdly [2];
  int delay_fixed;
  int nchk = 0, npass = 0;
  mem_arbiter #(.NUM_CHANNELS(2)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_ready(crr),
    .consumer_read_address(cra), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd), .mem_write_ready(mwr)
  );
  always #5 clk = ~clk;
  // Memory: ready comes after delay extra cycles of valid; reads return rom, writes are logged.
  always @(negedge clk)
    for (int c = 0; c < 2; c++) begin
      rcnt[c] = mrv[c] ? rcnt[c] + 1 : 0;
      if (rcnt[c] == 1) rdly[c] = delay_fixed < 0 ? int'($urandom_range(0, 3)) : delay_fixed;
      mrr[c] = mrv[c] && rcnt[c] > rdly[c];
      mrd[c*8 +: 8] = mrr[c] ? rom[mra[c*8 +: 8]] : 8'h00;
      wcnt[c] = mwv[c] ? wcnt[c] + 1 : 0;
      if (wcnt[c] == 1) wdly[c] = delay_fixed < 0 ? int'($urandom_range(0, 3)) : delay_fixed;
      mwr[c] = mwv[c] && wcnt[c] > wdly[c];
      if (mwr[c]) wlog[mwa[c*8 +: 8]] = {1'b1, mwd[c*8 +: 8]};
    end
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    nchk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else npass++;
  endtask
  function automatic logic [7:0] rdata(int i);
    return crd[i*8 +: 8];
  endfunction
  task automatic set_read(int i, logic v, logic [7:0] a);
    crv[i] = v;
    cra[i*8 +: 8] = a;
  endtask
  task automatic set_write(int i, logic v, logic [7:0] a, logic [7:0] d);
    cwv[i] = v;
    cwa[i*8 +: 8] = a;
    cwd[i*8 +: 8] = d;
  endtask
  task automatic wait_ready(int i, bit wr, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wr ? cwr[i] : crr[i]) && n < 100);
  endtask
  initial begin
    int n;
    bit stable;
    int left [4], age [4];
    bit busy [4], is_wr [4], drop [4];
    logic [7:0] addr [4], dat [4];
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'($urandom);
      wlog[i] = '0;
    end
    rom[8'h10] = 8'h5A;
    reset = 1'b1;
    crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
    delay_fixed = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", {crr, cwr}, 0);
    check("rst_mem_valid", {mrv, mwv}, 0);
    check("rst_mem_bus", {mra, mwa, mwd}, 0);
    check("rst_rdata", crd, 0);
    reset = 1'b0;
    set_read(2, 1'b1, 8'h10);
    @(negedge clk);
    check("rd1_not_ready", crr, 0);
    check("rd1_mem_valid", mrv, 2'b01);
    check("rd1_mem_addr", mra[7:0], 8'h10);
    @(negedge clk);
    check("rd1_ready", crr, 4'b0100);
    check("rd1_data", rdata(2), 8'h5A);
    check("rd1_mem_dropped", mrv, 0);
    crv[2] = 1'b0;
    @(negedge clk);
    check("rd1_ready_drop", crr, 0);
    check("rd1_data_hold", rdata(2), 8'h5A);
    for (int i = 0; i < 4; i++) set_read(i, 1'b1, 8'(i + 1));
    @(negedge clk);
    check("c4_mem_valid", mrv, 2'b11);
    check("c4_mem_addr", mra, 16'h0201);
    @(negedge clk);
    check("c4_ready01", crr, 4'b0011);
    check("c4_data0", rdata(0), rom[1]);
    check("c4_data1", rdata(1), rom[2]);
    crv[1:0] = 2'b00;
    @(negedge clk);
    check("c4_gap_ready", crr, 0);
    check("c4_gap_mem", mrv, 0);
    @(negedge clk);
    check("c4_mem_valid2", mrv, 2'b11);
    check("c4_mem_addr2", mra, 16'h0403);
    @(negedge clk);
    check("c4_ready23", crr, 4'b1100);
    check("c4_data2", rdata(2), rom[3]);
    check("c4_data3", rdata(3), rom[4]);
    crv = '0;
    @(negedge clk);
    check("c4_ready_drop", crr, 0);
    delay_fixed = 4;
    set_write(1, 1'b1, 8'h20, 8'hAB);
    n = 0;
    stable = 1'b1;
    @(negedge clk);
    while (mwv[0] && n < 20) begin
      n++;
      if (mwa[7:0] != 8'h20 || mwd[7:0] != 8'hAB) stable = 1'b0;
      @(negedge clk);
    end
    check("wr_valid_cycles", n, 5);
    check("wr_stable", stable, 1);
    check("wr_ready", cwr, 4'b0010);
    check("wr_mem", wlog[8'h20], 9'h1AB);
    cwv[1] = 1'b0;
    @(negedge clk);
    check("wr_ready_drop", cwr, 0);
    delay_fixed = 10;
    set_read(0, 1'b1, 8'h30);
    repeat (2) @(negedge clk);
    check("rstmid_waiting", mrv, 2'b01);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_valid_ready", {mrv, mwv, crr, cwr}, 0);
    check("rstmid_mem_bus", {mra, mwa, mwd}, 0);
    check("rstmid_rdata", crd, 0);
    reset = 1'b0;
    delay_fixed = 0;
    wait_ready(0, 1'b0, n);
    check("rstmid_resume_latency", n, 2);
    check("rstmid_resume_data", rdata(0), rom[8'h30]);
    crv[0] = 1'b0;
    @(negedge clk);
    set_read(3, 1'b1, 8'h40);
    set_write(3, 1'b1, 8'h90, 8'h77);
    wait_ready(3, 1'b0, n);
    check("rw_read_first", {crr[3], cwr[3]}, 2'b10);
    check("rw_read_data", rdata(3), rom[8'h40]);
    check("rw_write_pending", wlog[8'h90], 0);
    crv[3] = 1'b0;
    wait_ready(3, 1'b1, n);
    check("rw_write_ready", cwr[3], 1);
    check("rw_write_mem", wlog[8'h90], 9'h177);
    cwv[3] = 1'b0;
    @(negedge clk);
    delay_fixed = -1;
    for (int i = 0; i < 4; i++) begin
      left[i] = 8; age[i] = 0; busy[i] = 0; drop[i] = 0; is_wr[i] = 0; addr[i] = 0; dat[i] = 0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (drop[i]) begin
          check("rnd_ready_low", is_wr[i] ? cwr[i] : crr[i], 0);
          drop[i] = 0;
        end
        if (busy[i]) begin
          age[i]++;
          if (is_wr[i] ? cwr[i] : crr[i]) begin
            if (is_wr[i]) begin
              check("rnd_write", wlog[addr[i]], {1'b1, dat[i]});
              cwv[i] = 1'b0;
            end else begin
              check("rnd_read", rdata(i), rom[addr[i]]);
              crv[i] = 1'b0;
            end
            busy[i] = 0; drop[i] = 1; left[i]--;
          end else if (age[i] > 200) begin
            check("rnd_timeout", is_wr[i] ? cwr[i] : crr[i], 1);
            crv[i] = 1'b0; cwv[i] = 1'b0; busy[i] = 0; left[i] = 0;
          end
        end else if (left[i] > 0 && $urandom_range(0, 1) == 1) begin
          is_wr[i] = $urandom_range(0, 2) == 0;
          dat[i] = 8'($urandom);
          if (is_wr[i]) begin
            addr[i] = 8'(8'h80 + i * 32 + int'($urandom_range(0, 31)));
            wlog[addr[i]] = '0;
            set_write(i, 1'b1, addr[i], dat[i]);
          end else begin
            addr[i] = 8'($urandom_range(0, 127));
            set_read(i, 1'b1, addr[i]);
          end
          busy[i] = 1; age[i] = 0;
        end
      end
      if (left[0] + left[1] + left[2] + left[3] == 0 && !(drop[0] || drop[1] || drop[2] || drop[3])) break;
    end
    check("rnd_all_done", left[0] + left[1] + left[2] + left[3], 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
